// File: rtl/calc_mport_engine_if.sv
// calc_mport_engine_if: request/response bus of the N-port calculator engine
// Signals (port p occupies [p*W +: W]):
//   req_cmd/req_tag/req_data  master -> slave  command, tag, operand1 then operand2
//   port_full                 slave -> master  port queue cannot accept a new command
//   out_resp/out_data/out_tag slave -> master  one-cycle response with echoed tag
interface calc_mport_engine_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W = 2
);
  logic [NUM_PORTS*4-1:0] req_cmd;
  logic [NUM_PORTS*TAG_W-1:0] req_tag;
  logic [NUM_PORTS*DATA_W-1:0] req_data;
  logic [NUM_PORTS-1:0] port_full;
  logic [NUM_PORTS*2-1:0] out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS*TAG_W-1:0] out_tag;
  modport master (output req_cmd, req_tag, req_data, input port_full, out_resp, out_data, out_tag);
  modport slave (input req_cmd, req_tag, req_data, output port_full, out_resp, out_data, out_tag);
endinterface

// File: rtl/calc_mport_engine.sv
// calc_mport_engine: N-port calculator with per-port capture FSM and FIFO, round-robin arbiter, shared registered ALU
// Ports: c_clk (rising edge), reset (synchronous, active-high),
//        bus (slave modport): req_* in, port_full and out_* registered out.
module calc_mport_engine #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic c_clk,
  input logic reset,
  calc_mport_engine_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(DATA_W);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int EW = 4 + TAG_W + 2 * DATA_W;
  typedef enum logic {IDLE, OP2} st_t;
  st_t r_st [NUM_PORTS];
  logic [3:0] r_cmd [NUM_PORTS];
  logic [TAG_W-1:0] r_tag [NUM_PORTS];
  logic [DATA_W-1:0] r_op1 [NUM_PORTS];
  logic [EW-1:0] r_mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0] r_wp [NUM_PORTS];
  logic [AW-1:0] r_rp [NUM_PORTS];
  logic [AW:0] r_cnt [NUM_PORTS];
  logic [AW:0] w_cnt_n [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_full, w_start, w_push, w_pop;
  logic [PW-1:0] r_last, w_gnt, w_idx;
  logic w_gnt_v;
  logic [3:0] w_c;
  logic [TAG_W-1:0] w_t;
  logic [DATA_W-1:0] w_a, w_b, w_res;
  logic [DATA_W:0] w_sum;
  logic [1:0] w_resp;
  logic [NUM_PORTS*2-1:0] r_resp;
  logic [NUM_PORTS*DATA_W-1:0] r_data;
  logic [NUM_PORTS*TAG_W-1:0] r_otag;
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_start[p] = r_st[p] == IDLE && bus.req_cmd[p*4 +: 4] != 4'd0 && !r_full[p];
      w_push[p] = r_st[p] == OP2;
      w_pop[p] = w_gnt_v && w_gnt == PW'(p);
      w_cnt_n[p] = r_cnt[p] + (AW+1)'(w_push[p]) - (AW+1)'(w_pop[p]);
    end
  end
  // Scan from the farthest port back to the nearest so the port right after r_last wins.
  always_comb begin
    w_gnt_v = 1'b0;
    w_gnt = r_last;
    w_idx = r_last;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      w_idx = PW'((int'(r_last) + i) % NUM_PORTS);
      if (r_cnt[w_idx] != '0) begin
        w_gnt_v = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  always_comb begin
    {w_c, w_t, w_a, w_b} = r_mem[w_gnt][r_rp[w_gnt]];
    w_sum = {1'b0, w_a} + {1'b0, w_b};
    w_resp = w_c == 4'd1 ? (w_sum[DATA_W] ? 2'd2 : 2'd1)
           : w_c == 4'd2 ? (w_b > w_a ? 2'd2 : 2'd1)
           : (w_c == 4'd5 || w_c == 4'd6) ? 2'd1 : 2'd3;
    w_res = w_resp != 2'd1 ? '0
          : w_c == 4'd1 ? w_sum[DATA_W-1:0]
          : w_c == 4'd2 ? w_a - w_b
          : w_c == 4'd5 ? w_a << w_b[SW-1:0] : w_a >> w_b[SW-1:0];
  end
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_last <= PW'(NUM_PORTS - 1);
      r_resp <= '0;
      r_data <= '0;
      r_otag <= '0;
      r_full <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_st[p] <= IDLE;
        r_wp[p] <= '0;
        r_rp[p] <= '0;
        r_cnt[p] <= '0;
      end
    end else begin
      r_resp <= '0;
      r_data <= '0;
      r_otag <= '0;
      if (w_gnt_v) begin
        r_last <= w_gnt;
        r_resp[w_gnt*2 +: 2] <= w_resp;
        r_data[w_gnt*DATA_W +: DATA_W] <= w_res;
        r_otag[w_gnt*TAG_W +: TAG_W] <= w_t;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_st[p] <= w_start[p] ? OP2 : IDLE;
        if (w_start[p]) begin
          r_cmd[p] <= bus.req_cmd[p*4 +: 4];
          r_tag[p] <= bus.req_tag[p*TAG_W +: TAG_W];
          r_op1[p] <= bus.req_data[p*DATA_W +: DATA_W];
        end
        if (w_push[p]) begin
          r_mem[p][r_wp[p]] <= {r_cmd[p], r_tag[p], r_op1[p], bus.req_data[p*DATA_W +: DATA_W]};
          r_wp[p] <= r_wp[p] + 1'b1;
        end
        if (w_pop[p]) r_rp[p] <= r_rp[p] + 1'b1;
        r_cnt[p] <= w_cnt_n[p];
        // Counts the entry being assembled so a started command always finds room on push.
        r_full[p] <= w_cnt_n[p] + (AW+1)'(w_start[p]) == (AW+1)'(FIFO_DEPTH);
      end
    end
  end
  assign bus.port_full = r_full;
  assign bus.out_resp = r_resp;
  assign bus.out_data = r_data;
  assign bus.out_tag = r_otag;
endmodule

// File: tb/tb_calc_mport_engine.sv
// tb_calc_mport_engine: directed scoreboard bench for calc_mport_engine
module tb_calc_mport_engine;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int D = 4;
  typedef struct packed {
    logic [1:0] port;
    logic [1:0] resp;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;
  logic c_clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  always #5 c_clk = ~c_clk;
  calc_mport_engine_if #(.NUM_PORTS(N), .DATA_W(DW), .TAG_W(TW)) bus ();
  calc_mport_engine #(.NUM_PORTS(N), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(D)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask
  task automatic put_cmd(int p, logic [3:0] c, logic [TW-1:0] t, logic [DW-1:0] a);
    bus.req_cmd[p*4 +: 4] = c;
    bus.req_tag[p*TW +: TW] = t;
    bus.req_data[p*DW +: DW] = a;
  endtask
  task automatic put_op2(int p, logic [DW-1:0] b);
    bus.req_cmd[p*4 +: 4] = 4'd0;
    bus.req_data[p*DW +: DW] = b;
  endtask
  task automatic expect_resp(int p, logic [1:0] er, logic [DW-1:0] ed, logic [TW-1:0] et);
    exp_t e;
    e.port = 2'(p);
    e.resp = er;
    e.data = ed;
    e.tag = et;
    sb.push_back(e);
  endtask
  task automatic issue(int p, logic [3:0] c, logic [TW-1:0] t, logic [DW-1:0] a, logic [DW-1:0] b,
                       logic [1:0] er, logic [DW-1:0] ed);
    put_cmd(p, c, t, a);
    tick();
    put_op2(p, b);
    expect_resp(p, er, ed, t);
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask
  // Every response is matched against the oldest expectation for its port.
  always @(negedge c_clk) if (mon_en) begin
    int hit, idx;
    hit = 0;
    for (int p = 0; p < N; p++) begin
      if (bus.out_resp[p*2 +: 2] !== 2'd0) begin
        hit++;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && int'(sb[i].port) == p) idx = i;
        if (idx < 0) chk($sformatf("unexpected_p%0d", p), 128'(bus.out_resp[p*2 +: 2]), 128'd0);
        else begin
          chk($sformatf("resp_p%0d", p),
              128'({bus.out_resp[p*2 +: 2], bus.out_data[p*DW +: DW], bus.out_tag[p*TW +: TW]}),
              128'({sb[idx].resp, sb[idx].data, sb[idx].tag}));
          sb.delete(idx);
        end
      end else chk($sformatf("idle_p%0d", p), 128'({bus.out_data[p*DW +: DW], bus.out_tag[p*TW +: TW]}), 128'd0);
    end
    chk("one_resp", 128'(hit <= 1), 128'd1);
  end
  initial begin
    logic [DW-1:0] ra, rb;
    int rp;
    bus.req_cmd = '0;
    bus.req_tag = '0;
    bus.req_data = '0;
    do_reset();
    mon_en = 1'b1;
    chk("rst_full", 128'(bus.port_full), 128'd0);
    chk("rst_resp", 128'(bus.out_resp), 128'd0);
    chk("rst_data", 128'(bus.out_data), 128'd0);
    chk("rst_tag", 128'(bus.out_tag), 128'd0);
    put_cmd(0, 4'd1, 2'd2, 32'h5);
    tick();
    put_op2(0, 32'h7);
    expect_resp(0, 2'd1, 32'hC, 2'd2);
    tick();
    chk("t1_early", 128'(bus.out_resp), 128'd0);
    tick();
    chk("t1_resp", 128'(bus.out_resp), 128'h01);
    chk("t1_data", 128'(bus.out_data), 128'hC);
    chk("t1_tag", 128'(bus.out_tag), 128'h2);
    tick();
    chk("t1_once", 128'(bus.out_resp), 128'd0);
    issue(1, 4'd1, 2'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'd0);
    issue(1, 4'd2, 2'd3, 32'd3, 32'd5, 2'd2, 32'd0);
    issue(1, 4'd2, 2'd0, 32'd5, 32'd3, 2'd1, 32'd2);
    issue(1, 4'd2, 2'd2, 32'd9, 32'd9, 2'd1, 32'd0);
    issue(1, 4'd4, 2'd2, 32'd9, 32'd9, 2'd3, 32'd0);
    issue(2, 4'd5, 2'd1, 32'h1, 32'h24, 2'd1, 32'h10);
    issue(2, 4'd6, 2'd3, 32'h8000_0000, 32'd31, 2'd1, 32'h1);
    issue(2, 4'd7, 2'd1, 32'h8, 32'h8, 2'd3, 32'd0);
    for (int i = 0; i < 6; i++) begin
      ra = DW'($urandom_range(0, 100000));
      rb = DW'($urandom_range(0, 100000));
      rp = int'($urandom_range(0, N - 1));
      issue(rp, 4'd1, TW'(i), ra, rb, 2'd1, ra + rb);
    end
    drain();
    do_reset();
    for (int p = 0; p < N; p++) put_cmd(p, 4'd1, TW'(p), DW'(p * 10));
    tick();
    for (int p = 0; p < N; p++) begin
      put_op2(p, 32'd1);
      expect_resp(p, 2'd1, DW'(p * 10 + 1), TW'(p));
    end
    tick();
    for (int p = 0; p < N; p++) put_cmd(p, 4'd2, TW'(3 - p), DW'(p * 10 + 50));
    tick();
    for (int p = 0; p < N; p++) begin
      put_op2(p, 32'd5);
      expect_resp(p, 2'd1, DW'(p * 10 + 45), TW'(3 - p));
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_order_%0d", k), 128'(bus.out_resp), 128'(1) << (2 * (k % 4)));
      tick();
    end
    drain();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < N; p++) put_cmd(p, 4'd1, TW'(p), DW'(p * 16 + c));
      tick();
      for (int p = 0; p < N; p++) begin
        put_op2(p, 32'd1);
        expect_resp(p, 2'd1, DW'(p * 16 + c + 1), TW'(p));
      end
      tick();
    end
    chk("full_set", 128'(bus.port_full[3]), 128'd1);
    put_cmd(3, 4'd1, 2'd1, 32'hDEAD);
    tick();
    put_op2(3, 32'd1);
    tick();
    chk("full_clear", 128'(bus.port_full[3]), 128'd0);
    issue(3, 4'd1, 2'd2, 32'h77, 32'h5, 2'd1, 32'h7C);
    drain();
    put_cmd(0, 4'd2, 2'd1, 32'd50);
    tick();
    put_op2(0, 32'd8);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_rst_full", 128'(bus.port_full), 128'd0);
    put_cmd(0, 4'd1, 2'd3, 32'd100);
    tick();
    put_op2(0, 32'd23);
    expect_resp(0, 2'd1, 32'd123, 2'd3);
    tick();
    tick();
    chk("post_rst_resp", 128'(bus.out_resp), 128'h01);
    chk("post_rst_data", 128'(bus.out_data), 128'd123);
    tick();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_mport_engine.md
# calc_mport_engine

Parametrised N-port calculator engine, the next generation of the four-port calc1 design. Each port accepts two-cycle commands (command/tag/operand1, then operand2) into a per-port request FIFO. A round-robin arbiter feeds one shared pipelined ALU, and results return on the originating port with the request tag echoed. Adds over calc1: configurable port count, data width and queue depth, explicit back-pressure (`port_full`), and a distinct invalid-command response.

## Interface

Parameters:
- NUM_PORTS, 4, number of request/response ports (1..8)
- DATA_W, 32, operand/result width (8..64, power of two)
- TAG_W, 2, tag width
- FIFO_DEPTH, 4, entries per port queue (power of two, ≥2)

Ports (per-port buses are flattened; port p occupies slice [p*W +: W]):
- c_clk  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising c_clk
- req_cmd  in  NUM_PORTS*4  command per port; 0=no-op, 1=add, 2=sub, 5=shl, 6=shr, others invalid
- req_tag  in  NUM_PORTS*TAG_W  tag, sampled with command
- req_data  in  NUM_PORTS*DATA_W  operand1 in command cycle, operand2 in next cycle
- port_full  out  NUM_PORTS  port queue cannot accept a new command this cycle
- out_resp  out  NUM_PORTS*2  0=none, 1=success, 2=overflow/underflow, 3=invalid command
- out_data  out  NUM_PORTS*DATA_W  result; 0 unless out_resp==1
- out_tag  out  NUM_PORTS*TAG_W  echoed tag; 0 when out_resp==0

## Operation

- **Capture, per port, 2-state FSM (IDLE, OP2):**
  - IDLE: on a nonzero req_cmd with port_full=0, latch cmd, tag and operand1, then go to OP2.
  - IDLE: a nonzero req_cmd with port_full=1 is dropped silently and produces no response.
  - OP2: latch operand2, push the entry into the port FIFO, return to IDLE.
  - req_cmd is ignored in the OP2 cycle. A command cannot start in the cycle that leaves OP2 unless that cycle is IDLE; back-to-back commands therefore use cycles t, t+2, t+4, …
- **port_full:** registered. It is 1 when FIFO occupancy plus the entry being assembled equals FIFO_DEPTH.
- **Arbiter:** each cycle, grant one port whose FIFO is non-empty, searching round-robin starting at the port after the last grant. Pop the granted entry. There is no grant when all FIFOs are empty.
- **ALU (unsigned, DATA_W bits):**
  - add: carry-out → resp 2, data 0; else resp 1, data = sum.
  - sub: operand2 > operand1 → resp 2, data 0; else resp 1, data = difference.
  - shl/shr: logical shift of operand1 by operand2[log2(DATA_W)-1:0]; resp 1, no overflow.
  - invalid command: resp 3, data 0.
- **Response:** at most one port responds per cycle. out_resp, out_data and out_tag for that port are valid for exactly one cycle; all other ports read 0.
- **Ordering:** responses on a port are returned in FIFO order. Across ports, order follows arbitration.

## Timing

- **Reset:** all outputs 0, FIFOs empty, capture FSMs to IDLE, round-robin pointer so port 0 has first priority, ALU pipeline flushed.
- **Reset mid-operation:** partially captured and queued commands are discarded, and responses already in the pipeline are suppressed (outputs 0 from the cycle after reset is sampled).
- **Latency:** command in cycle t, operand2 in t+1, FIFO write at the end of t+1, grant in t+2, ALU registered at the end of t+2, response visible in cycle t+3 when uncontended.
- **Throughput:** one response per cycle aggregate; one command per two cycles per port.
- **Simultaneous push and pop on the same FIFO:** occupancy unchanged. A pop from a full FIFO and a capture start in the same cycle are permitted only if port_full was already 0.
- **port_full timing:** updates on the clock after occupancy changes. A command presented while port_full=0 is always accepted.
- **Fairness:** with all ports continuously backlogged, each port is granted once every NUM_PORTS cycles.

## Test plan

- Port 0: cmd=1, tag=2, op1=0x0000_0005, op2=0x0000_0007 → cycle t+3 port 0: resp=1, data=0x0000_000C, tag=2; all other ports 0.
- Port 1: add 0xFFFF_FFFF + 1 → resp=2, data=0; sub 3-5 → resp=2; cmd=4 → resp=3, data=0, tag echoed.
- Port 2: shl op1=0x1, op2=0x24 (DATA_W=32, shift 4) → 0x10; shr op1=0x8000_0000, op2=31 → 0x1.
- All 4 ports issue an add in the same cycle t → one response per cycle in t+3..t+6 in order port0, 1, 2, 3; a second wave starts at port 0 after the pointer wraps.
- Port 3 issues FIFO_DEPTH commands while the arbiter is kept busy by the other ports → port_full=1. A further command is dropped with no response; after one pop, port_full→0 and a new command is accepted.
- Reset asserted one cycle after an operand2 cycle → no response ever appears, port_full=0, and a subsequent command completes with normal t+3 latency.
